// File: rtl/sim_host_pkg.sv
// Shared types and defaults for the simulation host monitor.
package sim_host_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_PUTCHAR_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR    = 32'h1000_1000;
  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [7:0]  DEF_PASS_CODE    = 8'h03;

  // Channel index width; a single channel still carries one bit.
  function automatic int chan_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sim_host_monitor_if.sv
// Bus snoop, console stream and verdict signals of the host monitor.
interface sim_host_monitor_if #(
  parameter int CHAN_W = 1
);
  logic              mem_valid;
  logic              mem_write;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic [CHAN_W-1:0] out_chan;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [31:0]       exit_code;
  logic [15:0]       dropped;
  logic [31:0]       cycles;

  modport master (
    output mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, out_ready,
    input  out_valid, out_char, out_chan, done, pass, fail, timeout,
           exit_code, dropped, cycles
  );

  modport slave (
    input  mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, out_ready,
    output out_valid, out_char, out_chan, done, pass, fail, timeout,
           exit_code, dropped, cycles
  );
endinterface

// File: rtl/sim_host_fifo.sv
// Synchronous FIFO with registered storage; pointers carry an extra MSB
// so full and empty are told apart without a counter.
module sim_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the stream outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sim_host_monitor.sv
// Memory-bus snooper: console FIFO, exit/tohost verdicts and run watchdog.
// Optional feature macro: SIM_HOST_TIMEOUT_EN (watchdog compare logic).
module sim_host_monitor
  import sim_host_pkg::*;
#(
  parameter logic [31:0] PUTCHAR_ADDR   = DEF_PUTCHAR_ADDR,
  parameter int          CHANNELS       = 1,
  parameter logic [31:0] EXIT_ADDR      = DEF_EXIT_ADDR,
  parameter logic [7:0]  PASS_CODE      = DEF_PASS_CODE,
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input logic               clk,
  input logic               rst,
  sim_host_monitor_if.slave bus
);
  localparam int CW = chan_w(CHANNELS);
  localparam int DW = CW + 8;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_strobe, w_in_run, w_con_hit, w_exit_hit, w_tohost_hit;
  logic          w_term, w_wdog, w_push, w_pop, w_full, w_empty;
  logic [31:0]   w_off;
  logic [DW-1:0] w_fifo_dout;
  logic          r_done, r_pass, r_fail;
  logic [31:0]   r_exit_code;
  logic [15:0]   r_dropped;
  logic [31:0]   r_cycles;
  logic          w_unused;

  assign w_unused     = ^bus.mem_wmask[3:1];
  assign w_strobe     = bus.mem_valid & bus.mem_write & bus.mem_wmask[0];
  assign w_in_run     = (r_state == ST_RUN);
  assign w_off        = bus.mem_addr - PUTCHAR_ADDR;
  assign w_con_hit    = w_strobe & w_in_run & (w_off[1:0] == 2'b00) &
                        (w_off[31:2] < 30'(CHANNELS));
  assign w_exit_hit   = w_strobe & w_in_run & (bus.mem_addr == EXIT_ADDR);
  assign w_tohost_hit = w_strobe & w_in_run & (bus.mem_addr == TOHOST_ADDR) &
                        (bus.mem_wdata != 32'd0);
  assign w_term       = w_exit_hit | w_tohost_hit;
  assign w_pop        = ~w_empty & bus.out_ready;
  // A full FIFO still takes a character when the head leaves this cycle.
  assign w_push       = w_con_hit & (~w_full | w_pop);

  sim_host_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({w_off[2 +: CW], bus.mem_wdata[7:0]}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_fifo_dout)
  );

`ifdef SIM_HOST_TIMEOUT_EN
  logic r_timeout;
  assign w_wdog = w_in_run & (TIMEOUT_CYCLES != 0) &
                  (r_cycles == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_wdog & ~w_term) begin
      r_timeout <= 1'b1;
    end
  end
  assign bus.timeout = r_timeout;
`else
  assign w_wdog      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_term | w_wdog) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Exit register wins over tohost if both decode the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_exit_code <= 32'd0;
    end else if (w_exit_hit) begin
      r_exit_code <= bus.mem_wdata;
      r_pass      <= (bus.mem_wdata[7:0] == PASS_CODE);
      r_fail      <= (bus.mem_wdata[7:0] != PASS_CODE);
    end else if (w_tohost_hit) begin
      r_exit_code <= bus.mem_wdata;
      r_pass      <= (bus.mem_wdata == 32'd1);
      r_fail      <= (bus.mem_wdata != 32'd1);
    end else if (w_wdog) begin
      r_exit_code <= 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles  <= 32'd0;
      r_dropped <= 16'd0;
    end else begin
      if (w_in_run) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_con_hit & ~w_push & (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_chan  = w_fifo_dout[DW-1:8];
  assign bus.out_char  = w_fifo_dout[7:0];
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail      = r_fail;
  assign bus.exit_code = r_exit_code;
  assign bus.dropped   = r_dropped;
  assign bus.cycles    = r_cycles;
endmodule

// File: tb/tb_sim_host_monitor.sv
// Directed bench: console streaming, drops, verdicts, drain and watchdog.
module tb_sim_host_monitor;
  import sim_host_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_t;
  int   n_checks = 0;
  int   n_errors = 0;

  sim_host_monitor_if #(.CHAN_W(1)) ifa ();
  sim_host_monitor_if #(.CHAN_W(1)) ift ();

  sim_host_monitor #(
    .CHANNELS(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

  sim_host_monitor #(
    .CHANNELS(1), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(100)
  ) dut_t (.clk(clk), .rst(rst_t), .bus(ift));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    ifa.mem_valid = 1'b1; ifa.mem_write = 1'b1; ifa.mem_wmask = m;
    ifa.mem_addr = a; ifa.mem_wdata = d;
    @(negedge clk);
    ifa.mem_valid = 1'b0; ifa.mem_write = 1'b0; ifa.mem_wmask = 4'h0;
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [31:0] d);
    ift.mem_valid = 1'b1; ift.mem_write = 1'b1; ift.mem_wmask = 4'hF;
    ift.mem_addr = a; ift.mem_wdata = d;
    @(negedge clk);
    ift.mem_valid = 1'b0; ift.mem_write = 1'b0; ift.mem_wmask = 4'h0;
  endtask

  initial begin
    rst_a = 1'b1; rst_t = 1'b1;
    ifa.mem_valid = 1'b0; ifa.mem_write = 1'b0; ifa.mem_wmask = 4'h0;
    ifa.mem_addr = 32'd0; ifa.mem_wdata = 32'd0; ifa.out_ready = 1'b0;
    ift.mem_valid = 1'b0; ift.mem_write = 1'b0; ift.mem_wmask = 4'h0;
    ift.mem_addr = 32'd0; ift.mem_wdata = 32'd0; ift.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_char", 32'(ifa.out_char), 32'd0);
    chk("rst_chan", 32'(ifa.out_chan), 32'd0);
    chk("rst_flags", 32'({ifa.done, ifa.pass, ifa.fail, ifa.timeout}), 32'd0);
    chk("rst_exit", ifa.exit_code, 32'd0);
    chk("rst_dropped", 32'(ifa.dropped), 32'd0);
    chk("rst_cycles", ifa.cycles, 32'd0);
    rst_a = 1'b0;

    ifa.out_ready = 1'b1;
    wr_a(32'h1000_0000, 32'h48, 4'hF);
    chk("h_valid", 32'(ifa.out_valid), 32'd1);
    chk("h_char", 32'(ifa.out_char), 32'h48);
    chk("h_chan", 32'(ifa.out_chan), 32'd0);
    wr_a(32'h1000_0000, 32'h69, 4'hF);
    chk("i_valid", 32'(ifa.out_valid), 32'd1);
    chk("i_char", 32'(ifa.out_char), 32'h69);
    @(negedge clk);
    chk("hi_drained", 32'(ifa.out_valid), 32'd0);

    wr_a(32'h1000_0000, 32'h5A, 4'hE);
    chk("mask0_ignored", 32'(ifa.out_valid), 32'd0);

    wr_a(32'h1000_0004, 32'h41, 4'hF);
    chk("ch1_valid", 32'(ifa.out_valid), 32'd1);
    chk("ch1_chan", 32'(ifa.out_chan), 32'd1);
    chk("ch1_char", 32'(ifa.out_char), 32'h41);
    @(negedge clk);
    wr_a(32'h1000_0008, 32'h42, 4'hF);
    chk("ch2_out_of_range", 32'(ifa.out_valid), 32'd0);
    chk("ch2_no_drop", 32'(ifa.dropped), 32'd0);

    ifa.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_a(32'h1000_0000, 32'h61 + 32'(i), 4'hF);
    end
    chk("full_dropped", 32'(ifa.dropped), 32'd2);
    chk("full_head_held", 32'(ifa.out_char), 32'h61);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_valid", 32'(ifa.out_valid), 32'd1);
      chk("full_drain_char", 32'(ifa.out_char), 32'h61 + 32'(i));
      @(negedge clk);
    end
    chk("full_drain_empty", 32'(ifa.out_valid), 32'd0);

    ifa.out_ready = 1'b0;
    wr_a(32'h1000_0000, 32'h78, 4'hF);
    wr_a(32'h1000_0000, 32'h79, 4'hF);
    wr_a(32'h1000_0000, 32'h7A, 4'hF);
    wr_a(32'h1000_1000, 32'h03, 4'hF);
    chk("exit_pass", 32'(ifa.pass), 32'd1);
    chk("exit_fail", 32'(ifa.fail), 32'd0);
    chk("exit_code", ifa.exit_code, 32'h03);
    chk("exit_not_done", 32'(ifa.done), 32'd0);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_char", 32'(ifa.out_char), 32'h78 + 32'(i));
      chk("drain_not_done", 32'(ifa.done), 32'd0);
      @(negedge clk);
    end
    chk("drain_empty", 32'(ifa.out_valid), 32'd0);
    chk("drain_done_wait", 32'(ifa.done), 32'd0);
    @(negedge clk);
    chk("drain_done", 32'(ifa.done), 32'd1);
    wr_a(32'h1000_0000, 32'h51, 4'hF);
    chk("done_console_ignored", 32'(ifa.out_valid), 32'd0);
    chk("done_no_drop", 32'(ifa.dropped), 32'd2);
    wr_a(32'h1000_1000, 32'h55, 4'hF);
    chk("done_exit_ignored", ifa.exit_code, 32'h03);

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    ifa.out_ready = 1'b0;
    wr_a(32'h1000_0000, 32'h52, 4'hF);
    chk("midrst_queued", 32'(ifa.out_valid), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(ifa.out_valid), 32'd0);
    chk("midrst_char", 32'(ifa.out_char), 32'd0);
    chk("midrst_pass", 32'(ifa.pass), 32'd0);
    chk("midrst_dropped", 32'(ifa.dropped), 32'd0);
    rst_a = 1'b0;
    ifa.out_ready = 1'b1;

    wr_a(32'h0000_1000, 32'h0, 4'hF);
    chk("tohost0_ignored", 32'({ifa.pass, ifa.fail, ifa.done}), 32'd0);
    wr_a(32'h0000_1000, 32'h7, 4'hF);
    chk("tohost_fail", 32'(ifa.fail), 32'd1);
    chk("tohost_no_pass", 32'(ifa.pass), 32'd0);
    chk("tohost_code", ifa.exit_code, 32'h7);
    chk("tohost_not_done", 32'(ifa.done), 32'd0);
    @(negedge clk);
    chk("tohost_done", 32'(ifa.done), 32'd1);

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wr_a(32'h0000_1000, 32'h1, 4'hF);
    chk("tohost1_pass", 32'(ifa.pass), 32'd1);
    chk("tohost1_fail", 32'(ifa.fail), 32'd0);

    rst_t = 1'b0;
`ifdef SIM_HOST_TIMEOUT_EN
    repeat (99) @(negedge clk);
    chk("wd_before", 32'(ift.timeout), 32'd0);
    chk("wd_before_cycles", ift.cycles, 32'd99);
    @(negedge clk);
    chk("wd_timeout", 32'(ift.timeout), 32'd1);
    chk("wd_cycles", ift.cycles, 32'd100);
    chk("wd_code", ift.exit_code, 32'd0);
    chk("wd_no_verdict", 32'({ift.pass, ift.fail}), 32'd0);
    @(negedge clk);
    chk("wd_done", 32'(ift.done), 32'd1);
    repeat (5) @(negedge clk);
    chk("wd_cycles_frozen", ift.cycles, 32'd100);
    rst_t = 1'b1;
    @(negedge clk);
    chk("wd_rst_cycles", ift.cycles, 32'd0);
    chk("wd_rst_timeout", 32'(ift.timeout), 32'd0);
    rst_t = 1'b0;
    repeat (99) @(negedge clk);
    wr_t(32'h1000_1000, 32'h03);
    chk("wd_race_pass", 32'(ift.pass), 32'd1);
    chk("wd_race_timeout", 32'(ift.timeout), 32'd0);
    chk("wd_race_cycles", ift.cycles, 32'd100);
`else
    repeat (120) @(negedge clk);
    chk("nowd_timeout", 32'(ift.timeout), 32'd0);
    chk("nowd_cycles", ift.cycles, 32'd120);
    chk("nowd_not_done", 32'(ift.done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
